// File: rtl/trig_fire_arbiter.sv
// -----------------------------------------------------------------------------
// trig_fire_arbiter
//
// Purpose:
//   Shares the trigger board's coax outputs between NTRIG trigger-bit
//   requesters. The first eligible request is granted. Every further bit that
//   asserts inside the collection window is ORed into the same trigger. The
//   outputs fire once, a dead time follows, and one record (bit mask, granting
//   bit index, grant timestamp) per trigger is queued in a small FIFO for
//   slow-control readout.
//
// Ports (all in the clk_adc domain):
//   clk_adc        sole clock
//   reset          asynchronous, active-high reset
//   clear          synchronous flush (FSM idle, FIFO empty, drop count zero)
//   trig_req       per-bit level requests
//   trig_enable    per-bit enable mask
//   gate           global arm; requests are ignored while low
//   collect_time   collection window in cycles (0 behaves as 1)
//   dead_time      dead time after the window in cycles
//   pulse_len      coax pulse width in cycles (0 = no pulse)
//   timestamp      free-running counter, latched at grant
//   coax_out       all ones while the pulse counter is nonzero
//   busy           high while collecting or in dead time
//   rec_valid      record FIFO not empty
//   rec_ready      consumer accepts the head record
//   rec_bits       head record trigger mask
//   rec_first      head record index of the granting bit
//   rec_time       head record timestamp
//   dropped_count  records lost to a full FIFO, saturating
//   dbg_state      current FSM state (0 idle, 1 collect, 2 dead)
//
// Record handshake: the head record is transferred on every clock edge where
// rec_valid && rec_ready. rec_valid never depends on rec_ready, and the head
// fields hold stable while rec_valid is high and rec_ready is low.
// -----------------------------------------------------------------------------
module trig_fire_arbiter #(
  parameter int NTRIG      = 8,
  parameter int TS_W       = 56,
  parameter int NOUT       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_adc,
  input  logic             reset,
  input  logic             clear,
  input  logic [NTRIG-1:0] trig_req,
  input  logic [NTRIG-1:0] trig_enable,
  input  logic             gate,
  input  logic [7:0]       collect_time,
  input  logic [7:0]       dead_time,
  input  logic [5:0]       pulse_len,
  input  logic [TS_W-1:0]  timestamp,
  output logic [NOUT-1:0]  coax_out,
  output logic             busy,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [NTRIG-1:0] rec_bits,
  output logic [2:0]       rec_first,
  output logic [TS_W-1:0]  rec_time,
  output logic [15:0]      dropped_count,
  output logic [1:0]       dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DEAD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NTRIG-1:0] bits_q, bits_d;
  logic [2:0]       first_q, first_d;
  logic [TS_W-1:0]  time_q, time_d;
  logic [7:0]       ccnt_q, ccnt_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic [7:0]       dcfg_q, dcfg_d;
  logic [5:0]       pcnt_q, pcnt_d;
  logic [NOUT-1:0]  coax_q, coax_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      drop_q, drop_d;

  logic [NTRIG-1:0] elig;
  logic [2:0]       first_idx;
  logic             push;
  logic [NTRIG-1:0] push_bits;
  logic             pop;
  logic             full;
  logic             accept;
  logic             mem_we;

  logic [NTRIG-1:0] mem_bits  [FIFO_DEPTH];
  logic [2:0]       mem_first [FIFO_DEPTH];
  logic [TS_W-1:0]  mem_time  [FIFO_DEPTH];

  always_comb begin
    elig = trig_req & trig_enable & {NTRIG{gate}};

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    first_idx = '0;
    for (int i = NTRIG - 1; i >= 0; i--) begin
      if (elig[i]) first_idx = 3'(i);
    end

    state_d   = state_q;
    bits_d    = bits_q;
    first_d   = first_q;
    time_d    = time_q;
    ccnt_d    = ccnt_q;
    dcnt_d    = dcnt_q;
    dcfg_d    = dcfg_q;
    push      = 1'b0;
    push_bits = bits_q | elig;

    // The pulse counter runs independently of the FSM and is reloaded only at grant.
    pcnt_d = (pcnt_q != 6'd0) ? pcnt_q - 6'd1 : 6'd0;

    case (state_q)
      S_IDLE: begin
        if (elig != '0) begin
          state_d = S_COLLECT;
          bits_d  = elig;
          first_d = first_idx;
          time_d  = timestamp;
          pcnt_d  = pulse_len;
          // The grant cycle is the first window cycle, so the counter holds
          // the remaining window cycles. A window of 0 or 1 still spends one
          // cycle in COLLECT.
          ccnt_d  = (collect_time > 8'd1) ? collect_time - 8'd1 : 8'd0;
          dcfg_d  = dead_time;
        end
      end
      S_COLLECT: begin
        bits_d = bits_q | elig;
        ccnt_d = (ccnt_q != 8'd0) ? ccnt_q - 8'd1 : 8'd0;
        if (ccnt_q <= 8'd1) begin
          push = 1'b1;
          if (dcfg_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DEAD;
            dcnt_d  = dcfg_q;
          end
        end
      end
      S_DEAD: begin
        dcnt_d = (dcnt_q != 8'd0) ? dcnt_q - 8'd1 : 8'd0;
        if (dcnt_q <= 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Record FIFO. A push into a full FIFO is still accepted when the head
    // leaves in the same cycle.
    full   = (cnt_q == CW'(FIFO_DEPTH));
    pop    = (cnt_q != '0) && rec_ready;
    accept = push && (!full || pop);
    wr_d   = wr_q + PW'(accept);
    rd_d   = rd_q + PW'(pop);
    cnt_d  = cnt_q + CW'(accept) - CW'(pop);
    drop_d = drop_q;
    if (push && !accept && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    // Clear wins over grant, push and pop.
    if (clear) begin
      state_d = S_IDLE;
      bits_d  = '0;
      first_d = '0;
      time_d  = '0;
      ccnt_d  = '0;
      dcnt_d  = '0;
      dcfg_d  = '0;
      pcnt_d  = '0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      drop_d  = '0;
    end
    mem_we = accept && !clear;

    coax_d = {NOUT{pcnt_d != 6'd0}};
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_adc or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bits_q  <= '0;
      first_q <= '0;
      time_q  <= '0;
      ccnt_q  <= '0;
      dcnt_q  <= '0;
      dcfg_q  <= '0;
      pcnt_q  <= '0;
      coax_q  <= '0;
      busy_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      first_q <= first_d;
      time_q  <= time_d;
      ccnt_q  <= ccnt_d;
      dcnt_q  <= dcnt_d;
      dcfg_q  <= dcfg_d;
      pcnt_q  <= pcnt_d;
      coax_q  <= coax_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk_adc) begin
    if (mem_we) begin
      mem_bits[wr_q]  <= push_bits;
      mem_first[wr_q] <= first_q;
      mem_time[wr_q]  <= time_q;
    end
  end

  assign coax_out      = coax_q;
  assign busy          = busy_q;
  assign rec_valid     = (cnt_q != '0);
  assign rec_bits      = rec_valid ? mem_bits[rd_q]  : '0;
  assign rec_first     = rec_valid ? mem_first[rd_q] : '0;
  assign rec_time      = rec_valid ? mem_time[rd_q]  : '0;
  assign dropped_count = drop_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_trig_fire_arbiter.sv
module tb_trig_fire_arbiter;

  localparam int NTRIG = 8;
  localparam int TS_W  = 56;
  localparam int NOUT  = 16;
  localparam int DEPTH = 4;
  localparam int REC_W = NTRIG + 3 + TS_W;

  logic             clk_adc;
  logic             reset;
  logic             clear;
  logic [NTRIG-1:0] trig_req;
  logic [NTRIG-1:0] trig_enable;
  logic             gate;
  logic [7:0]       collect_time;
  logic [7:0]       dead_time;
  logic [5:0]       pulse_len;
  logic [TS_W-1:0]  timestamp;
  logic [NOUT-1:0]  coax_out;
  logic             busy;
  logic             rec_valid;
  logic             rec_ready;
  logic [NTRIG-1:0] rec_bits;
  logic [2:0]       rec_first;
  logic [TS_W-1:0]  rec_time;
  logic [15:0]      dropped_count;
  logic [1:0]       dbg_state;

  trig_fire_arbiter #(
    .NTRIG(NTRIG), .TS_W(TS_W), .NOUT(NOUT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_adc(clk_adc), .reset(reset), .clear(clear),
    .trig_req(trig_req), .trig_enable(trig_enable), .gate(gate),
    .collect_time(collect_time), .dead_time(dead_time), .pulse_len(pulse_len),
    .timestamp(timestamp), .coax_out(coax_out), .busy(busy),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_bits(rec_bits),
    .rec_first(rec_first), .rec_time(rec_time),
    .dropped_count(dropped_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_adc = 1'b0;
    forever #5 clk_adc = ~clk_adc;
  end

  initial begin
    timestamp = 56'({$urandom(), $urandom()});
    forever begin
      @(posedge clk_adc);
      #1;
      timestamp = timestamp + 56'd1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works in absolute cycle numbers: a grant at cycle n owns the window
  // n..win_last, makes the block unavailable until next_free and drives the
  // pulse through pulse_end.
  logic [REC_W-1:0] exp_q[$];
  int               cyc = 0;
  int               next_free = 0;
  int               busy_from = 0;
  int               pulse_end = -1;
  int               win_last = 0;
  bit               in_win = 0;
  logic [NTRIG-1:0] acc_bits;
  logic [2:0]       acc_first;
  logic [TS_W-1:0]  acc_time;
  int               m_drop = 0;

  function automatic logic [2:0] lowest_bit(input logic [NTRIG-1:0] v);
    for (int i = 0; i < NTRIG; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  initial begin
    logic [NTRIG-1:0] e;
    int c;
    forever begin
      @(posedge clk_adc);
      if (reset) begin
        in_win = 0; next_free = 0; busy_from = 0; pulse_end = -1;
        exp_q.delete(); m_drop = 0;
      end else begin
        e = trig_req & trig_enable & {NTRIG{gate}};
        if (clear) begin
          in_win = 0; next_free = cyc + 1; pulse_end = cyc;
          exp_q.delete(); m_drop = 0;
        end else if (in_win) begin
          acc_bits = acc_bits | e;
          if (cyc == win_last) begin
            in_win = 0;
            // Monitor already removed this cycle's pop, so a full FIFO
            // that is being read still takes the record.
            if (exp_q.size() < DEPTH) exp_q.push_back({acc_bits, acc_first, acc_time});
            else if (m_drop < 65535) m_drop++;
          end
        end else if (cyc >= next_free && e != '0) begin
          c = (collect_time > 8'd1) ? int'(collect_time) : 1;
          acc_bits  = e;
          acc_first = lowest_bit(e);
          acc_time  = timestamp;
          win_last  = cyc + ((c > 1) ? c - 1 : 1);
          next_free = win_last + 1 + int'(dead_time);
          busy_from = cyc + 1;
          pulse_end = cyc + int'(pulse_len);
          in_win    = 1;
        end
      end
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [REC_W-1:0] r;
    forever begin
      @(negedge clk_adc);
      if (!reset) begin
        chk("coax_out", 64'(coax_out), (cyc <= pulse_end) ? 64'hFFFF : 64'h0);
        chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc < next_free));
        chk("rec_valid", 64'(rec_valid), 64'(exp_q.size() != 0));
        chk("dropped_count", 64'(dropped_count), 64'(m_drop));
        if (exp_q.size() != 0 && rec_ready) begin
          r = exp_q.pop_front();
          chk("rec_bits", 64'(rec_bits), 64'(r[REC_W-1 -: NTRIG]));
          chk("rec_first", 64'(rec_first), 64'(r[TS_W +: 3]));
          chk("rec_time", 64'(rec_time), 64'(r[TS_W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_adc);
    #1;
  endtask

  task automatic set_cfg(input int c, input int d, input int p);
    collect_time = 8'(c);
    dead_time    = 8'(d);
    pulse_len    = 6'(p);
  endtask

  task automatic pulse_req(input logic [NTRIG-1:0] b);
    trig_req = b;
    tick(1);
    trig_req = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_coax"}, 64'(coax_out), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_valid"}, 64'(rec_valid), 64'h0);
    chk({tag, "_bits"}, 64'(rec_bits), 64'h0);
    chk({tag, "_first"}, 64'(rec_first), 64'h0);
    chk({tag, "_time"}, 64'(rec_time), 64'h0);
    chk({tag, "_drop"}, 64'(dropped_count), 64'h0);
    chk({tag, "_state"}, 64'(dbg_state), 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    reset = 1'b1; clear = 1'b0; trig_req = '0; trig_enable = 8'hFF; gate = 1'b1;
    rec_ready = 1'b1;
    set_cfg(4, 10, 16);
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Single grant: bit 2 for one cycle.
    pulse_req(8'h04);
    tick(20);

    // Collection OR: bit 5 at N, bit 0 at N+2, bit 7 at N+4 (dead time).
    rec_ready = 1'b0;
    trig_req = 8'h20; tick(1);
    trig_req = 8'h00; tick(1);
    trig_req = 8'h01; tick(1);
    trig_req = 8'h00; tick(1);
    trig_req = 8'h80; tick(1);
    trig_req = 8'h00;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rec_valid) got = 1;
      else tick(1);
    end
    chk("or_wait_valid", 64'(got), 64'h1);
    chk("or_bits", 64'(rec_bits), 64'h21);
    chk("or_first", 64'(rec_first), 64'h5);
    rec_ready = 1'b1; tick(1); rec_ready = 1'b0;
    tick(12);

    // Masking: disabled bit and gate low give no grant.
    trig_enable = 8'hFE; trig_req = 8'h01; tick(5);
    chk("mask_busy", 64'(busy), 64'h0);
    trig_enable = 8'hFF; gate = 1'b0; trig_req = 8'hFF; tick(5);
    chk("gate_busy", 64'(busy), 64'h0);
    trig_req = '0; gate = 1'b1; tick(2);

    // Overflow: five triggers with nobody reading.
    set_cfg(2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      pulse_req(8'($urandom_range(1, 255)));
      tick(6);
    end
    chk("ovf_drop", 64'(dropped_count), 64'h1);
    chk("ovf_valid", 64'(rec_valid), 64'h1);
    // Push and pop in the same cycle while full: no further drop.
    trig_req = 8'($urandom_range(1, 255)); tick(1);
    trig_req = '0; rec_ready = 1'b1; tick(1); rec_ready = 1'b0;
    tick(5);
    chk("ovf_pushpop_drop", 64'(dropped_count), 64'h1);

    // Clear with three records queued.
    rec_ready = 1'b1; tick(1); rec_ready = 1'b0;
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("clear_valid", 64'(rec_valid), 64'h0);
    chk("clear_drop", 64'(dropped_count), 64'h0);
    tick(2);

    // Zero configs: one-cycle collect, regrant two cycles after the first.
    set_cfg(0, 0, 0);
    rec_ready = 1'b1;
    trig_req = 8'h10; tick(4);
    trig_req = '0; tick(5);

    // Reset while collecting.
    rec_ready = 1'b0;
    set_cfg(8, 5, 20);
    pulse_req(8'h08);
    tick(2);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk_adc); #1;
    reset = 1'b0;
    tick(12);
    chk("post_reset_valid", 64'(rec_valid), 64'h0);

    // Randomized traffic.
    set_cfg(3, 2, 5);
    for (int i = 0; i < 800; i++) begin
      trig_req    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      trig_enable = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
      gate        = ($urandom_range(0, 9) != 0);
      rec_ready   = ($urandom_range(0, 2) == 0);
      clear       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0)
        set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 10));
      tick(1);
    end
    trig_req = '0; clear = 1'b0; rec_ready = 1'b1;
    tick(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
